countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter that is the counterpart to the game's up-counting score/length counter. The move/step scheduler loads it with an interval, and it counts down on each enabled cycle. When it reaches zero it signals expiry, which the game FSM uses to pace snake movement and timeouts. It sits between the tick-prescaler enable and the game control FSM.

## Interface
- WIDTH, 5, bit width of count and load value (matches the 5-bit datapath)
- clock  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  count enable (prescaled tick); decrement only when high
- start  input  1  load load_value and begin counting (single-cycle strobe)
- stop  input  1  abort counting, hold count, return to idle
- load_value  input  WIDTH  interval to count down from
- count  output  WIDTH  current counter value (registered)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in the cycle count becomes 0 through counting or zero-load
- expired  output  1  level, high in DONE until next start or reset

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: count=0, busy=0, done=0, expired=0, internal reload register=0.
- Priority each cycle: reset > stop > start > en.
- IDLE: start=1 → count<=load_value, reload<=load_value, go RUN. If load_value==0 → count<=0, go DONE, done=1 next cycle. en ignored.
- RUN: busy=1.
  - stop=1 → IDLE; count holds its current value; no done.
  - start=1 → reload from load_value (restart), stay RUN; the en of that cycle is ignored.
  - en=1 and count>1 → count<=count-1.
  - en=1 and count==1 → count<=0, go DONE, done=1 next cycle.
  - en=0 → hold.
- DONE: count=0, expired=1, busy=0. start=1 → same as IDLE start. stop=1 → IDLE, expired clears.
- Arithmetic: unsigned WIDTH-bit. No decrement occurs below 0, so there is no wrap. Max load 2^WIDTH-1 (31 at default).
- done is registered and never high for more than one consecutive cycle unless expiries occur on consecutive cycles (auto-reload with load 1).

## Timing
- start sampled at edge N: count=load_value and busy=1 from cycle N+1.
- With en held high from N+1: count=load_value-k at N+1+k. count=0, done=1, expired=1 at N+1+load_value.
- Zero-load start at N: done=1, expired=1 at N+1.
- stop at edge M: busy=0 at M+1.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous). Operation resumes only on a start after deassertion.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined:
  - In RUN, en=1 with count==1 → count<=reload, done=1 next cycle, stay RUN, busy stays 1, expired never set.
  - A zero-load start still goes to DONE (no reload of 0).
  - Only stop, or reset, leaves RUN.
- Not defined: one-shot behaviour as described in Operation. The reload register may be optimised away.

## Test plan
- Reset, then start with load_value=5, en=1 continuously → count 5,4,3,2,1,0 on cycles N+1..N+6. done=1 only at N+6; busy drops at N+6; expired stays 1.
- load_value=3, en toggling 1,0,1,0,1 → count decrements only on en cycles. done fires 6 cycles after load, not 3.
- start with load_value=0 → next cycle count=0, done=1, expired=1, busy=0.
- Running at count=4: assert stop and start in the same cycle → IDLE, count=4, busy=0, no done. A later start with load_value=31 → count=31.
- Running at count=2: assert reset for one cycle mid-cycle → count=0, busy=0, done=0, expired=0 immediately. Remains IDLE with en high.
- COUNTDOWN_AUTORELOAD_EN, load_value=2, en=1 → count 2,1,2,1,…, with done pulsing every 2 cycles and busy constant 1. Then stop → IDLE.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Purpose : Groups the control inputs and status outputs of countdown_timer.
// Ports   : en_i/start_i/stop_i/load_value_i drive the timer (master side);
//           count_o/busy_o/done_o/expired_o report its state (slave side).
interface countdown_timer_if #(
    parameter int WIDTH = 5
) ();

    logic             en_i;          // prescaled tick, decrement enable
    logic             start_i;       // single-cycle load-and-go strobe
    logic             stop_i;        // abort, hold count, return to idle
    logic [WIDTH-1:0] load_value_i;  // interval to count down from
    logic [WIDTH-1:0] count_o;       // registered counter value
    logic             busy_o;        // high while counting
    logic             done_o;        // one-cycle expiry pulse
    logic             expired_o;     // level, high while sitting in DONE

    // Scheduler / game FSM side.
    modport master (
        output en_i,
        output start_i,
        output stop_i,
        output load_value_i,
        input  count_o,
        input  busy_o,
        input  done_o,
        input  expired_o
    );

    // Timer side.
    modport slave (
        input  en_i,
        input  start_i,
        input  stop_i,
        input  load_value_i,
        output count_o,
        output busy_o,
        output done_o,
        output expired_o
    );

endinterface

// File: rtl/countdown_timer.sv
// Purpose : Loadable down-counter that paces snake movement / timeouts; signals
//           expiry with a one-cycle done pulse and a sticky expired level.
// Ports   : clk_i, rst_i (async, active-high) plus tmr (countdown_timer_if.slave).
// Latency : start at edge N -> count=load_value, busy=1 from N+1; with en held
//           high, count=0 and done=1 at N+1+load_value (N+1 for a zero load).
// Config  : define COUNTDOWN_AUTORELOAD_EN to reload the interval on expiry and
//           keep running instead of parking in DONE.
module countdown_timer #(
    parameter int WIDTH = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    countdown_timer_if.slave  tmr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q,  done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
    // Interval captured at start, reused on every expiry while running.
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    logic             busy;
    logic             expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= CNT_ZERO;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= CNT_ZERO;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: stop > start > en.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (tmr.stop_i) begin
                    // count is already 0 in DONE and held in IDLE
                    state_d = S_IDLE;
                end else if (tmr.start_i) begin
                    count_d  = tmr.load_value_i;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    reload_d = tmr.load_value_i;
`endif
                    // A zero interval expires at once rather than running.
                    if (tmr.load_value_i == CNT_ZERO) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (tmr.stop_i) begin
                    state_d = S_IDLE;
                end else if (tmr.start_i) begin
                    // Restart; the en of this cycle is deliberately dropped.
                    count_d  = tmr.load_value_i;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    reload_d = tmr.load_value_i;
`endif
                    if (tmr.load_value_i == CNT_ZERO) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (tmr.en_i) begin
                    if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        // Expiry. The <=1 test also keeps a stray 0 from
                        // wrapping, so the counter can never go below zero.
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        // reload_q is non-zero here: zero loads never enter RUN.
                        count_d = reload_q;
`else
                        count_d = CNT_ZERO;
                        state_d = S_DONE;
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                count_d = CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (from registered state only, so outputs are glitch-free)
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        expired = 1'b0;
        case (state_q)
            S_RUN:   busy    = 1'b1;
            S_DONE:  expired = 1'b1;
            default: ;
        endcase
    end

    assign tmr.count_o   = count_q;
    assign tmr.done_o    = done_q;
    assign tmr.busy_o    = busy;
    assign tmr.expired_o = expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each stimulus cycle pushes the outputs
// expected after the next rising edge; a monitor pops and compares on the
// falling edge.
module tb_countdown_timer;

    typedef struct packed {
        logic [4:0] count;
        logic       busy;
        logic       done;
        logic       expired;
    } obs_t;

    logic clk;
    logic rst;

    countdown_timer_if #(.WIDTH(5)) tif ();

    countdown_timer #(.WIDTH(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .tmr   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    obs_t  mon_exp;
    obs_t  mon_act;
    string mon_nm;

    task automatic check(input string nm, input obs_t act, input obs_t expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got count=%0d busy=%0b done=%0b expired=%0b, expected count=%0d busy=%0b done=%0b expired=%0b",
                     nm, act.count, act.busy, act.done, act.expired,
                     expv.count, expv.busy, expv.done, expv.expired);
        end
    endtask

    // Monitor: compares outputs produced by the preceding rising edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = nm_q.pop_front();
            mon_act = '{tif.count_o, tif.busy_o, tif.done_o, tif.expired_o};
            check(mon_nm, mon_act, mon_exp);
        end
    end

    // One clock of stimulus plus the outputs expected after its rising edge.
    task automatic cyc(input logic en, input logic st, input logic sp,
                       input logic [4:0] lv,
                       input logic [4:0] c, input logic b, input logic d,
                       input logic x, input string nm);
        obs_t e;
        tif.en_i         = en;
        tif.start_i      = st;
        tif.stop_i       = sp;
        tif.load_value_i = lv;
        e = '{c, b, d, x};
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t act;
        rst              = 1'b1;
        tif.en_i         = 1'b0;
        tif.start_i      = 1'b0;
        tif.stop_i       = 1'b0;
        tif.load_value_i = '0;
        @(negedge clk);
        #1;

        // Reset state, and reset dominating a start
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, "reset_hold");
        cyc(1, 1, 0, 5'd5, 5'd0, 0, 0, 0, "reset_dominates");
        rst = 1'b0;
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, "idle_en_ignored");

        // Zero load from IDLE goes straight to DONE
        cyc(0, 1, 0, 5'd0, 5'd0, 0, 1, 1, "zero_load");
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, "zero_load_hold");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 1, "done_en_ignored");
        cyc(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, "done_stop");

`ifndef COUNTDOWN_AUTORELOAD_EN
        // load 5, en continuous: 5,4,3,2,1,0
        cyc(1, 1, 0, 5'd5, 5'd5, 1, 0, 0, "ld5_start");
        cyc(1, 0, 0, 5'd0, 5'd4, 1, 0, 0, "ld5_cnt4");
        cyc(1, 0, 0, 5'd0, 5'd3, 1, 0, 0, "ld5_cnt3");
        cyc(1, 0, 0, 5'd0, 5'd2, 1, 0, 0, "ld5_cnt2");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 0, 0, "ld5_cnt1");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 1, 1, "ld5_expire");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 1, "ld5_after");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 1, "ld5_after2");

        // load 3 from DONE, en toggling 1,0,1,0,1
        cyc(0, 1, 0, 5'd3, 5'd3, 1, 0, 0, "ld3_start");
        cyc(1, 0, 0, 5'd0, 5'd2, 1, 0, 0, "ld3_en1");
        cyc(0, 0, 0, 5'd0, 5'd2, 1, 0, 0, "ld3_en0");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 0, 0, "ld3_en1b");
        cyc(0, 0, 0, 5'd0, 5'd1, 1, 0, 0, "ld3_en0b");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 1, 1, "ld3_expire");
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 0, 1, "ld3_after");
        cyc(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, "ld3_stop");
`else
        // load 2 with auto-reload: 2,1,2,1,... done every 2nd cycle
        cyc(1, 1, 0, 5'd2, 5'd2, 1, 0, 0, "ar2_start");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 0, 0, "ar2_cnt1");
        cyc(1, 0, 0, 5'd0, 5'd2, 1, 1, 0, "ar2_reload1");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 0, 0, "ar2_cnt1b");
        cyc(1, 0, 0, 5'd0, 5'd2, 1, 1, 0, "ar2_reload2");
        cyc(0, 0, 0, 5'd0, 5'd2, 1, 0, 0, "ar2_hold");
        cyc(0, 0, 1, 5'd0, 5'd2, 0, 0, 0, "ar2_stop");

        // load 1: done on consecutive cycles
        cyc(1, 1, 0, 5'd1, 5'd1, 1, 0, 0, "ar1_start");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 1, 0, "ar1_reload1");
        cyc(1, 0, 0, 5'd0, 5'd1, 1, 1, 0, "ar1_reload2");
        cyc(1, 0, 1, 5'd0, 5'd1, 0, 0, 0, "ar1_stop");
`endif

        // stop beats start; count held in IDLE; restart within RUN
        cyc(1, 1, 0, 5'd7,  5'd7,  1, 0, 0, "ld7_start");
        cyc(1, 0, 0, 5'd0,  5'd6,  1, 0, 0, "ld7_cnt6");
        cyc(1, 0, 0, 5'd0,  5'd5,  1, 0, 0, "ld7_cnt5");
        cyc(1, 0, 0, 5'd0,  5'd4,  1, 0, 0, "ld7_cnt4");
        cyc(1, 1, 1, 5'd9,  5'd4,  0, 0, 0, "stop_beats_start");
        cyc(1, 0, 0, 5'd0,  5'd4,  0, 0, 0, "idle_holds_count");
        cyc(0, 1, 0, 5'd31, 5'd31, 1, 0, 0, "ld31_start");
        cyc(1, 0, 0, 5'd0,  5'd30, 1, 0, 0, "ld31_cnt30");
        cyc(1, 1, 0, 5'd10, 5'd10, 1, 0, 0, "restart_en_ignored");
        cyc(1, 0, 0, 5'd0,  5'd9,  1, 0, 0, "restart_cnt9");

        // Asynchronous reset mid-run at count 2
        cyc(1, 1, 0, 5'd3, 5'd3, 1, 0, 0, "ld3r_start");
        cyc(1, 0, 0, 5'd0, 5'd2, 1, 0, 0, "ld3r_cnt2");
        #2;
        rst = 1'b1;
        #1;
        act = '{tif.count_o, tif.busy_o, tif.done_o, tif.expired_o};
        check("async_reset", act, obs_t'('0));
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, "reset_held_run");
        rst = 1'b0;
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, "idle_after_reset");
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, "idle_after_reset2");
        cyc(1, 1, 0, 5'd2, 5'd2, 1, 0, 0, "resume_start");

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
